rs_station: RTL and testbench
=============================

Name: rs_station

Overview:
- Reservation station for one functional-unit class (adder or multiplier).
- Sits directly downstream of the common data bus: accepts issued instructions, snoops the CDB broadcast (tag + data) to resolve pending operands, and dispatches ready instructions to its functional unit.
- The FU later returns the entry's tag/result to the CDB input stage.
- One instance per FU class, distinguished by TAG_BASE.

Parameters:
- NUM_ENTRIES, 3: number of station entries (1..7).
- TAG_BASE, 1: tag of entry 0; entry i owns tag TAG_BASE+i; must be nonzero, TAG_BASE+NUM_ENTRIES-1 <= 15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  issue request this cycle.
- issue_ready  output  1  a free entry exists.
- issue_tag  output  4  tag of the entry the next issue will occupy; valid when issue_ready.
- issue_op  input  2  operation code.
- issue_vj  input  32  operand j value (used when issue_qj==0).
- issue_qj  input  4  producer tag for j; 0 = value present.
- issue_vk  input  32  operand k value.
- issue_qk  input  4  producer tag for k; 0 = value present.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  4  broadcast tag (never 0 when valid).
- cdb_data  input  32  broadcast result.
- disp_valid  output  1  an entry is ready for the FU.
- disp_ready  input  1  FU accepts this cycle.
- disp_op  output  2  op of dispatched entry.
- disp_a  output  32  operand j value.
- disp_b  output  32  operand k value.
- disp_tag  output  4  tag of dispatched entry.

Behaviour:
- Reset (async, active-high): all entries not busy; all Q fields 0. While reset is high: issue_ready=1, issue_tag=TAG_BASE, disp_valid=0, disp_op/disp_a/disp_b=0, disp_tag=0. Reset mid-operation discards all entries; nothing is dispatched afterwards.
- Per-entry state: busy, op, Vj, Qj, Vk, Qk.
- Issue:
  - Fires when issue_valid && issue_ready; allocates the lowest-index free entry.
  - issue_ready and issue_tag depend only on registered state. An entry freed by dispatch in the same cycle is not visible to issue until the next cycle.
  - issue_valid while !issue_ready is ignored.
- CDB snoop, each cycle cdb_valid=1:
  - Every busy entry with Qj==cdb_tag loads Vj<=cdb_data and Qj<=0. Same for k.
  - Both operands may resolve in the same cycle.
- Issue/CDB bypass: if an issuing instruction has issue_qj==cdb_tag (nonzero) while cdb_valid, the entry stores Vj=cdb_data, Qj=0. Same for k. Operands are never lost to a same-cycle broadcast.
- Ready condition: busy && Qj==0 && Qk==0, evaluated on registered state. An operand captured from the CDB this cycle becomes dispatchable next cycle, giving a 1-cycle minimum CDB-to-dispatch latency.
- Dispatch:
  - Combinational from state. Selects the lowest-index ready entry.
  - disp_* are held stable while disp_valid && !disp_ready.
  - On disp_valid && disp_ready, that entry's busy bit clears at the clock edge.
  - When disp_valid=0, disp_op/a/b/tag drive 0.
- Minimum issue-to-dispatch latency with both operands present: 1 cycle (issue at edge N, disp_valid during cycle N+1).
- Full: all entries busy gives issue_ready=0. Empty: disp_valid=0.
- Simultaneous issue + dispatch + CDB in one cycle are all legal and independent.
- The station does not free entries on CDB broadcast of its own tags. The FU owns the tag after dispatch.

Decomposition:
- Package tomasulo_pkg, holding:
  - TAG_W=4, DATA_W=32.
  - NO_TAG=4'd0.
  - op_e enum: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - rs_entry_t struct {busy, op, vj, qj, vk, qk}.
- Sub-module rs_entry: one entry's registers, plus CDB capture, issue load, clear-on-dispatch, and a ready output. rs_station instantiates NUM_ENTRIES of these, with priority encoders for allocation and dispatch selection.

Test Plan:
- Reset then issue ADD vj=5, qj=0, vk=7, qk=0: issue_tag=1; next cycle disp_valid=1, disp_a=5, disp_b=7, disp_tag=1; disp_ready=1 frees the entry.
- Issue qj=6, vk=3, qk=0; hold 3 cycles: disp_valid=0. Then CDB tag=6, data=0x10: the following cycle disp_a=0x10, disp_b=3.
- Issue with qk=9 in the same cycle as CDB tag=9, data=0xAA (bypass): the entry stores Vk=0xAA and dispatches next cycle with disp_b=0xAA.
- Fill 3 entries, all waiting on tag 8: issue_ready=0 and a 4th issue is ignored. CDB tag=8 makes all 3 ready; with disp_ready=1 they dispatch in order of tags 1,2,3 on consecutive cycles.
- disp_ready=0 for 4 cycles with 1 ready entry: disp_* are stable throughout; the entry is freed only on the cycle disp_ready=1.
- Assert reset with 2 busy entries mid-dispatch stall: disp_valid=0 immediately (async), issue_ready=1, issue_tag=1; after release, no stale dispatch occurs.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared widths, opcodes and entry record for the reservation stations
package tomasulo_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [TAG_W-1:0] NO_TAG = 4'd0;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef struct packed {
        logic              busy;
        op_e               op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

    // A pending operand is satisfied by a broadcast of its producer tag.
    function automatic logic cdb_hit(input logic valid, input logic [TAG_W-1:0] bcast,
                                     input logic [TAG_W-1:0] q);
        return valid && (q != NO_TAG) && (q == bcast);
    endfunction

endpackage

// File: rtl/rs_station_if.sv
// rtl/rs_station_if.sv - issue, CDB snoop and dispatch signals of one reservation station
interface rs_station_if;
    import tomasulo_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [1:0]        issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [TAG_W-1:0]  issue_qj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qk;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              disp_valid;
    logic              disp_ready;
    logic [1:0]        disp_op;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic [TAG_W-1:0]  disp_tag;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
        output cdb_valid, cdb_tag, cdb_data,
        output disp_ready,
        input  issue_ready, issue_tag,
        input  disp_valid, disp_op, disp_a, disp_b, disp_tag
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data,
        input  disp_ready,
        output issue_ready, issue_tag,
        output disp_valid, disp_op, disp_a, disp_b, disp_tag
    );

endinterface

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation-station slot with CDB capture and issue bypass
module rs_entry
    import tomasulo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  op_e               issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              busy,
    output op_e               op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk,
    output logic              ready
);

    rs_entry_t st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= '0;
        end else if (load) begin
            // Load only targets a free slot, so it never collides with clear.
            st.busy <= 1'b1;
            st.op   <= issue_op;
            if (cdb_hit(cdb_valid, cdb_tag, issue_qj)) begin
                st.vj <= cdb_data;
                st.qj <= NO_TAG;
            end else begin
                st.vj <= issue_vj;
                st.qj <= issue_qj;
            end
            if (cdb_hit(cdb_valid, cdb_tag, issue_qk)) begin
                st.vk <= cdb_data;
                st.qk <= NO_TAG;
            end else begin
                st.vk <= issue_vk;
                st.qk <= issue_qk;
            end
        end else begin
            if (clear) begin
                st.busy <= 1'b0;
            end
            if (st.busy && cdb_hit(cdb_valid, cdb_tag, st.qj)) begin
                st.vj <= cdb_data;
                st.qj <= NO_TAG;
            end
            if (st.busy && cdb_hit(cdb_valid, cdb_tag, st.qk)) begin
                st.vk <= cdb_data;
                st.qk <= NO_TAG;
            end
        end
    end

    assign busy  = st.busy;
    assign op    = st.op;
    assign vj    = st.vj;
    assign vk    = st.vk;
    assign ready = st.busy && (st.qj == NO_TAG) && (st.qk == NO_TAG);

endmodule

// File: rtl/rs_station.sv
// rtl/rs_station.sv - reservation station: lowest-free allocation, CDB snoop, lowest-ready dispatch
module rs_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_BASE    = 1
) (
    input  logic         clk,
    input  logic         reset,
    rs_station_if.slave  bus
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] busy;
    logic [NUM_ENTRIES-1:0] ready;
    logic [NUM_ENTRIES-1:0] load;
    logic [NUM_ENTRIES-1:0] clear;
    op_e                    ent_op [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_vj [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_vk [NUM_ENTRIES];

    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] held_idx;
    logic             alloc_ok;
    logic             any_ready;
    logic             held_valid;
    logic             fire_issue;
    logic             fire_disp;

    op_e               d_op;
    logic [DATA_W-1:0] d_a;
    logic [DATA_W-1:0] d_b;
    logic [TAG_W-1:0]  d_tag;

    always_comb begin
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // A stalled dispatch keeps its slot even if a lower slot becomes ready meanwhile.
    always_comb begin
        any_ready = |ready;
        sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        if (held_valid) begin
            sel_idx = held_idx;
        end
    end

    always_comb begin
        d_op  = OP_ADD;
        d_a   = '0;
        d_b   = '0;
        d_tag = NO_TAG;
        if (any_ready) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (sel_idx == IDX_W'(i)) begin
                    d_op  = ent_op[i];
                    d_a   = ent_vj[i];
                    d_b   = ent_vk[i];
                    d_tag = TAG_W'(TAG_BASE + i);
                end
            end
        end
    end

    assign fire_issue = bus.issue_valid && alloc_ok;
    assign fire_disp  = any_ready && bus.disp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_valid <= 1'b0;
            held_idx   <= '0;
        end else begin
            held_valid <= any_ready && !bus.disp_ready;
            held_idx   <= sel_idx;
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        assign load[g]  = fire_issue && (alloc_idx == IDX_W'(g));
        assign clear[g] = fire_disp && (sel_idx == IDX_W'(g));

        rs_entry u_entry (
            .clk       (clk),
            .reset     (reset),
            .load      (load[g]),
            .clear     (clear[g]),
            .issue_op  (op_e'(bus.issue_op)),
            .issue_vj  (bus.issue_vj),
            .issue_qj  (bus.issue_qj),
            .issue_vk  (bus.issue_vk),
            .issue_qk  (bus.issue_qk),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_data  (bus.cdb_data),
            .busy      (busy[g]),
            .op        (ent_op[g]),
            .vj        (ent_vj[g]),
            .vk        (ent_vk[g]),
            .ready     (ready[g])
        );
    end

    assign bus.issue_ready = alloc_ok;
    assign bus.issue_tag   = TAG_W'(TAG_BASE + int'(alloc_idx));
    assign bus.disp_valid  = any_ready;
    assign bus.disp_op     = d_op;
    assign bus.disp_a      = d_a;
    assign bus.disp_b      = d_b;
    assign bus.disp_tag    = d_tag;

endmodule

// File: tb/tb_rs_station.sv
// tb/tb_rs_station.sv - directed vector bench for rs_station
module tb_rs_station;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rs_station_if bus ();

    rs_station #(.NUM_ENTRIES(3), .TAG_BASE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  op;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        logic        dr;
        logic        e_ir;
        logic [3:0]  e_it;
        logic        e_dv;
        logic [1:0]  e_op;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  e_dt;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] op, input logic [31:0] vj,
                         input logic [3:0] qj, input logic [31:0] vk, input logic [3:0] qk,
                         input logic cv, input logic [3:0] ct, input logic [31:0] cd,
                         input logic dr);
        bus.issue_valid = iv;
        bus.issue_op    = op;
        bus.issue_vj    = vj;
        bus.issue_qj    = qj;
        bus.issue_vk    = vk;
        bus.issue_qk    = qk;
        bus.cdb_valid   = cv;
        bus.cdb_tag     = ct;
        bus.cdb_data    = cd;
        bus.disp_ready  = dr;
    endtask

    task automatic idle(input logic dr);
        drive(1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, dr);
    endtask

    // Issue tag is only meaningful while issue_ready, so it is checked only then.
    task automatic check_out(input string name, input logic e_ir, input logic [3:0] e_it,
                             input logic e_dv, input logic [1:0] e_op, input logic [31:0] e_a,
                             input logic [31:0] e_b, input logic [3:0] e_dt);
        chk({name, ".issue_ready"}, 32'(bus.issue_ready), 32'(e_ir));
        if (e_ir) chk({name, ".issue_tag"}, 32'(bus.issue_tag), 32'(e_it));
        chk({name, ".disp_valid"}, 32'(bus.disp_valid), 32'(e_dv));
        chk({name, ".disp_op"}, 32'(bus.disp_op), 32'(e_op));
        chk({name, ".disp_a"}, bus.disp_a, e_a);
        chk({name, ".disp_b"}, bus.disp_b, e_b);
        chk({name, ".disp_tag"}, 32'(bus.disp_tag), 32'(e_dt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle(1'b0);

        // iv op vj qj vk qk cv ct cd dr | ir it dv op a b dt
        vecs[0]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b0,  1'b1, 4'd1, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[1]  = '{1'b1, 2'd0, 32'h05, 4'd0, 32'h07, 4'd0, 1'b0, 4'd0, 32'h00, 1'b0,  1'b1, 4'd1, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[2]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b1, 2'd0, 32'h05, 32'h07, 4'd1};
        vecs[3]  = '{1'b1, 2'd1, 32'h00, 4'd6, 32'h03, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd1, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[4]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[5]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[6]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[7]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b1, 4'd6, 32'h10, 1'b1,  1'b1, 4'd2, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[8]  = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b1, 2'd1, 32'h10, 32'h03, 4'd1};
        vecs[9]  = '{1'b1, 2'd2, 32'h01, 4'd0, 32'h00, 4'd9, 1'b1, 4'd9, 32'hAA, 1'b0,  1'b1, 4'd1, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[10] = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b1, 2'd2, 32'h01, 32'hAA, 4'd1};
        vecs[11] = '{1'b1, 2'd3, 32'h00, 4'd8, 32'h11, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd1, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[12] = '{1'b1, 2'd3, 32'h00, 4'd8, 32'h12, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd2, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[13] = '{1'b1, 2'd3, 32'h00, 4'd8, 32'h13, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd3, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[14] = '{1'b1, 2'd0, 32'h99, 4'd0, 32'h99, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b0, 4'd0, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[15] = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b1, 4'd8, 32'h50, 1'b1,  1'b0, 4'd0, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};
        vecs[16] = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b0, 4'd0, 1'b1, 2'd3, 32'h50, 32'h11, 4'd1};
        vecs[17] = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd1, 1'b1, 2'd3, 32'h50, 32'h12, 4'd2};
        vecs[18] = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd1, 1'b1, 2'd3, 32'h50, 32'h13, 4'd3};
        vecs[19] = '{1'b0, 2'd0, 32'h00, 4'd0, 32'h00, 4'd0, 1'b0, 4'd0, 32'h00, 1'b1,  1'b1, 4'd1, 1'b0, 2'd0, 32'h00, 32'h00, 4'd0};

        #12;
        check_out("reset", 1'b1, 4'd1, 1'b0, 2'd0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].op, vecs[i].vj, vecs[i].qj, vecs[i].vk, vecs[i].qk,
                  vecs[i].cv, vecs[i].ct, vecs[i].cd, vecs[i].dr);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_it, vecs[i].e_dv,
                      vecs[i].e_op, vecs[i].e_a, vecs[i].e_b, vecs[i].e_dt);
            step();
        end

        // Stall: slot 1 dispatching while slot 0 resolves underneath it.
        drive(1'b1, 2'd0, 32'h0, 4'd5, 32'h22, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
        step();
        drive(1'b1, 2'd1, 32'h30, 4'd0, 32'h40, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("stall.alloc_tag", 32'(bus.issue_tag), 32'd2);
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) drive(1'b0, 2'd0, 32'h0, 4'd0, 32'h0, 4'd0, 1'b1, 4'd5, 32'h60, 1'b0);
            else        idle(1'b0);
            @(negedge clk);
            check_out($sformatf("stall%0d", k), 1'b1, 4'd3, 1'b1, 2'd1, 32'h30, 32'h40, 4'd2);
            step();
        end
        idle(1'b1);
        @(negedge clk);
        check_out("stall_release", 1'b1, 4'd3, 1'b1, 2'd1, 32'h30, 32'h40, 4'd2);
        step();
        idle(1'b0);
        @(negedge clk);
        check_out("after_release", 1'b1, 4'd2, 1'b1, 2'd0, 32'h60, 32'h22, 4'd1);

        // Reset with two busy entries, one stalled in dispatch.
        drive(1'b1, 2'd2, 32'h0, 4'd7, 32'h01, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
        step();
        idle(1'b0);
        chk("pre_reset.full_ready", 32'(bus.issue_ready), 32'd1);
        chk("pre_reset.tag", 32'(bus.issue_tag), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 1'b1, 4'd1, 1'b0, 2'd0, 32'h0, 32'h0, 4'd0);
        step();
        reset = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 4'd0, 32'h0, 4'd0, 1'b1, 4'd7, 32'h5, 1'b1);
        step();
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_out($sformatf("post_reset%0d", k), 1'b1, 4'd1, 1'b0, 2'd0, 32'h0, 32'h0, 4'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
